bkm_data_step_driver: RTL and testbench



---
 rtl/bkm_data_step_driver_pkg.sv | 14 +
 rtl/bkm_data_step_driver_bin2naf_step.sv | 34 +++
 rtl/bkm_data_step_driver.sv | 138 +++++++++++++
 tb/tb_bkm_data_step_driver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bkm_data_step_driver_pkg.sv
// Shared definitions for the bkm_data_step stimulus driver: digit codes and FSM states.
package bkm_data_step_driver_pkg;

  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_VALID
  } state_t;

endpackage

// File: rtl/bkm_data_step_driver_bin2naf_step.sv
// One LSB-first NAF digit step: picks the digit for the current residue and
// returns (v - d) >>> 1 as the next residue.
module bin2naf_step
  import bkm_data_step_driver_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W:0] v,
  output logic [1:0] digit,
  output logic [W:0] v_next
);

  localparam logic [W:0] ONE = (W+1)'(1);

  logic [W:0] adj;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    digit = CSD_ZERO;
    adj   = v;
    if (v[0]) begin
      if (v[1]) begin
        digit = CSD_NEG;
        adj   = v + ONE;
      end else begin
        digit = CSD_POS;
        adj   = {v[W:1], 1'b0};
      end
    end
    // adj is even here, so the arithmetic shift drops no information.
    v_next = {adj[W], adj[W:1]};
  end

endmodule

// File: rtl/bkm_data_step_driver.sv
// Stimulus driver: accepts binary operand pairs, converts them digit-serially
// to NAF and presents the CSD pair on a valid/ready port.
module bkm_data_step_driver
  import bkm_data_step_driver_pkg::*;
#(
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     X_n,
  input  logic [W-1:0]     Y_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   X_n_csd,
  output logic [2*W-1:0]   Y_n_csd,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int               DC_W       = $clog2(W+1);
  localparam logic [DC_W-1:0]  LAST_DIGIT = DC_W'(W-1);

  state_t             state_q, state_d;
  logic [DC_W-1:0]    dcnt_q, dcnt_d;
  logic [W:0]         xv_q, xv_d, yv_q, yv_d;
  logic [2*W-1:0]     xs_q, xs_d, ys_q, ys_d;
  logic [2*W-1:0]     x_csd_q, x_csd_d, y_csd_q, y_csd_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;

  logic [1:0]         x_dig, y_dig;
  logic [W:0]         x_vnext, y_vnext;

  bin2naf_step #(.W(W)) u_step_x (.v(xv_q), .digit(x_dig), .v_next(x_vnext));
  bin2naf_step #(.W(W)) u_step_y (.v(yv_q), .digit(y_dig), .v_next(y_vnext));

  assign in_ready  = enable && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_VALID);
  assign X_n_csd   = x_csd_q;
  assign Y_n_csd   = y_csd_q;
  assign vec_cnt   = vec_cnt_q;

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    xv_d      = xv_q;
    yv_d      = yv_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    x_csd_d   = x_csd_q;
    y_csd_d   = y_csd_q;
    vec_cnt_d = vec_cnt_q;

    if (srst) begin
      state_d   = ST_IDLE;
      dcnt_d    = '0;
      xv_d      = '0;
      yv_d      = '0;
      xs_d      = '0;
      ys_d      = '0;
      x_csd_d   = '0;
      y_csd_d   = '0;
      vec_cnt_d = '0;
    end else if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            xv_d    = {X_n[W-1], X_n};
            yv_d    = {Y_n[W-1], Y_n};
            dcnt_d  = '0;
            xs_d    = '0;
            ys_d    = '0;
            state_d = ST_CONV;
          end
        end
        ST_CONV: begin
          xv_d   = x_vnext;
          yv_d   = y_vnext;
          xs_d   = {x_dig, xs_q[2*W-1:2]};
          ys_d   = {y_dig, ys_q[2*W-1:2]};
          dcnt_d = dcnt_q + DC_W'(1);
          // The final digit goes straight into the output copy.
          if (dcnt_q == LAST_DIGIT) begin
            x_csd_d = xs_d;
            y_csd_d = ys_d;
            state_d = ST_VALID;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            vec_cnt_d = vec_cnt_q + CNT_W'(1);
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      dcnt_q    <= '0;
      xv_q      <= '0;
      yv_q      <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      x_csd_q   <= '0;
      y_csd_q   <= '0;
      vec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      xv_q      <= xv_d;
      yv_q      <= yv_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      x_csd_q   <= x_csd_d;
      y_csd_q   <= y_csd_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // A W-bit signed operand always fits in W NAF digits; leftover residue means broken conversion.
  always @(posedge clk) begin
    if (arst_n && !srst && enable && state_q == ST_CONV && dcnt_q == LAST_DIGIT &&
        (x_vnext != '0 || y_vnext != '0)) begin
      $error("bkm_data_step_driver: nonzero NAF residue x=%h y=%h", x_vnext, y_vnext);
    end
  end
`endif

endmodule

// File: tb/tb_bkm_data_step_driver.sv
// Directed and random checks of the NAF stimulus driver at W=8, with a small
// vector counter so wrap-around is exercised.
module tb_bkm_data_step_driver;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             arst_n, srst, enable, in_valid, out_ready;
  logic [W-1:0]     x_n, y_n;
  logic             in_ready, out_valid;
  logic [2*W-1:0]   x_csd, y_csd;
  logic [CNT_W-1:0] vec_cnt;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  bkm_data_step_driver #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .srst     (srst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X_n      (x_n),
    .Y_n      (y_n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .X_n_csd  (x_csd),
    .Y_n_csd  (y_csd),
    .vec_cnt  (vec_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    x_n      = x;
    y_n      = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  function automatic longint csd2bin(input logic [2*W-1:0] c);
    longint acc = 0;
    for (int i = 0; i < W; i++) begin
      case (c[2*i +: 2])
        2'b01:   acc += longint'(1) << i;
        2'b10:   acc -= longint'(1) << i;
        default: ;
      endcase
    end
    return acc;
  endfunction

  function automatic logic naf_ok(input logic [2*W-1:0] c);
    for (int i = 0; i < W; i++) begin
      if (c[2*i +: 2] == 2'b11) return 1'b0;
      if (i > 0 && c[2*i +: 2] != 2'b00 && c[2*i-2 +: 2] != 2'b00) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_pair(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] ex, input logic [2*W-1:0] ey);
    int lat;
    accept(x, y);
    wait_valid(lat);
    check({tag, "_latency"}, lat, W);
    check({tag, "_x_csd"}, x_csd, ex);
    check({tag, "_y_csd"}, y_csd, ey);
    tick();
    exp_cnt++;
    check({tag, "_vec_cnt"}, vec_cnt, exp_cnt);
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] ex;
    logic [2*W-1:0] ey;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   lat;
    logic [2*W-1:0] hold_x, hold_y;

    vecs[0] = '{8'h07, 8'hFF, 16'h0042, 16'h0002};
    vecs[1] = '{8'h80, 8'h7F, 16'h8000, 16'h4002};
    vecs[2] = '{8'h55, 8'h03, 16'h1111, 16'h0012};
    vecs[3] = '{8'h00, 8'h00, 16'h0000, 16'h0000};

    arst_n = 1'b0; srst = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x_n = '0; y_n = '0; exp_cnt = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_x_csd", x_csd, 0);
    check("rst_y_csd", y_csd, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    tick();
    arst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_pair($sformatf("dir%0d", i), vecs[i].x, vecs[i].y, vecs[i].ex, vecs[i].ey);

    // Backpressure, then an enable-low cycle while the consumer is ready.
    out_ready = 1'b0;
    accept(8'h07, 8'hFF);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_x_csd", x_csd, 16'h0042);
      check("bp_vec_cnt", vec_cnt, exp_cnt);
    end
    out_ready = 1'b1;
    enable    = 1'b0;
    tick();
    check("en_low_out_valid", out_valid, 1);
    check("en_low_vec_cnt", vec_cnt, exp_cnt);
    enable = 1'b1;
    tick();
    exp_cnt++;
    check("bp_release_vec_cnt", vec_cnt, exp_cnt);
    check("bp_hold_x_csd", x_csd, 16'h0042);
    check("bp_hold_y_csd", y_csd, 16'h0002);

    // Enable dropped for 3 cycles mid-conversion.
    accept(8'h55, 8'h03);
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 0);
    end
    enable = 1'b1;
    wait_valid(lat);
    check("stall_latency", lat + 5, W + 3);
    check("stall_x_csd", x_csd, 16'h1111);
    check("stall_y_csd", y_csd, 16'h0012);
    tick();
    exp_cnt++;
    check("stall_vec_cnt", vec_cnt, exp_cnt);

    // Async reset mid-conversion.
    accept(8'h80, 8'h7F);
    tick();
    tick();
    tick();
    arst_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("arst_out_valid", out_valid, 0);
    check("arst_vec_cnt", vec_cnt, 0);
    check("arst_x_csd", x_csd, 0);
    tick();
    arst_n = 1'b1;
    run_pair("post_arst", 8'h07, 8'hFF, 16'h0042, 16'h0002);

    // Sync reset while holding in VALID.
    out_ready = 1'b0;
    accept(8'h55, 8'h03);
    wait_valid(lat);
    srst = 1'b1;
    #1;
    check("srst_pre_edge_valid", out_valid, 1);
    tick();
    exp_cnt = '0;
    check("srst_out_valid", out_valid, 0);
    check("srst_vec_cnt", vec_cnt, 0);
    check("srst_y_csd", y_csd, 0);
    srst      = 1'b0;
    out_ready = 1'b1;

    // Random round-trip; the small counter wraps many times here.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] rx, ry;
      rx = W'($urandom);
      ry = W'($urandom);
      accept(rx, ry);
      wait_valid(lat);
      hold_x = x_csd;
      hold_y = y_csd;
      check("rnd_x_value", csd2bin(hold_x), longint'($signed(rx)));
      check("rnd_y_value", csd2bin(hold_y), longint'($signed(ry)));
      check("rnd_naf_form", {naf_ok(hold_x), naf_ok(hold_y)}, 2'b11);
      tick();
      exp_cnt++;
      check("rnd_vec_cnt", vec_cnt, exp_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
